// File: rtl/tt7_pkg.sv
// Shared types and constants for the 7-input truth-table extractor.
package tt7_pkg;

  localparam int unsigned NUM_VARS = 7;
  localparam int unsigned TT_BITS  = 1 << NUM_VARS;
  localparam int unsigned ONES_W   = NUM_VARS + 1;
  // Settle wait counter; wide enough for a load of 14 (SETTLE_CYCLES up to 15).
  localparam int unsigned CNT_W    = 4;

  typedef logic [TT_BITS-1:0]  tt_t;
  typedef logic [NUM_VARS-1:0] minterm_t;
  typedef logic [ONES_W-1:0]   ones_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    OUT
  } tt7_state_e;

  // One-hot write enable selecting the truth-table bit for a given minterm.
  function automatic tt_t onehot_enable(input minterm_t idx);
    tt_t en;
    en      = '0;
    en[idx] = 1'b1;
    return en;
  endfunction

endpackage

// File: rtl/tt7_extractor.sv
// Sequential truth-table reader: sweeps all 128 minterms of a 7-input network,
// samples its output once per minterm after a settle delay, and hands the table
// plus onset count to the consumer over a valid/ready handshake.
module tt7_extractor
  import tt7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  output logic                busy_o,
  output logic [NUM_VARS-1:0] x_o,
  input  logic                f_i,
  output logic [TT_BITS-1:0]  tt_o,
  output logic [ONES_W-1:0]   ones_o,
  output logic                tt_valid_o,
  input  logic                tt_ready_i
);

  // Counter counts down to zero, so SETTLE lasts exactly SETTLE_CYCLES cycles.
  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);

  tt7_state_e       state_q, state_d;
  minterm_t         x_q, x_d;
  tt_t              tt_q, tt_d;
  ones_t            ones_q, ones_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  tt_t wr_en;
  tt_t f_rep;

  // Decoded write enable for the current minterm and the sampled bit replicated.
  always_comb begin
    wr_en = onehot_enable(x_q);
    f_rep = {TT_BITS{f_i}};
  end

  // Next-state logic; f_i is only consumed in SAMPLE so X elsewhere never leaks in.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SETTLE;
          x_d     = '0;
          tt_d    = '0;
          ones_d  = '0;
          cnt_d   = SettleLoad;
        end
      end

      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      SAMPLE: begin
        tt_d   = (tt_q & ~wr_en) | (wr_en & f_rep);
        ones_d = ones_q + ONES_W'(f_i);
        if (x_q == '1) begin
          // Last minterm: x holds at 127 while the result is presented.
          state_d = OUT;
        end else begin
          x_d     = x_q + 1'b1;
          cnt_d   = SettleLoad;
          state_d = SETTLE;
        end
      end

      OUT: begin
        if (tt_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      tt_q    <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    busy_o     = (state_q == SETTLE) || (state_q == SAMPLE);
    tt_valid_o = (state_q == OUT);
    x_o        = x_q;
    tt_o       = tt_q;
    ones_o     = ones_q;
  end

endmodule

// File: tb/tb_tt7_extractor.sv
// Scoreboard bench for tt7_extractor: sweeps push expected results, monitors
// pop and compare whenever a result is handed over.
module tb_tt7_extractor;
  import tt7_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT with default settle delay
  logic          start, busy, f, valid, ready;
  logic [6:0]    x;
  logic [127:0]  tt;
  logic [7:0]    ones;

  // DUT with SETTLE_CYCLES = 3
  logic          start3, busy3, f3, valid3, ready3;
  logic [6:0]    x3;
  logic [127:0]  tt3;
  logic [7:0]    ones3;

  tt7_extractor #(.SETTLE_CYCLES(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .busy_o     (busy),
    .x_o        (x),
    .f_i        (f),
    .tt_o       (tt),
    .ones_o     (ones),
    .tt_valid_o (valid),
    .tt_ready_i (ready)
  );

  tt7_extractor #(.SETTLE_CYCLES(3)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start3),
    .busy_o     (busy3),
    .x_o        (x3),
    .f_i        (f3),
    .tt_o       (tt3),
    .ones_o     (ones3),
    .tt_valid_o (valid3),
    .tt_ready_i (ready3)
  );

  int n_vec = 0;
  int n_err = 0;

  // Network under test: mode selects the function presented on f.
  int     mode = 0;
  tt_t    maj_tt = 128'hfee8eee0fae8e8a0fae8e8a0f888e880;

  always_comb begin
    f = 1'b0;
    case (mode)
      0:       f = 1'b0;
      1:       f = 1'b1;
      2:       f = x[0];
      3:       f = x[6];
      default: f = maj_tt[x];
    endcase
  end

  always_comb f3 = x3[6];

  typedef struct {
    tt_t        tt;
    logic [7:0] ones;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] popcount(input tt_t v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 128; i++) c = c + 8'(v[i]);
    return c;
  endfunction

  // Monitor for the default DUT: a handover happens at the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid && ready) begin
        if (q1.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected result: got tt %0h ones %0d, none expected", tt, ones);
        end else begin
          e = q1.pop_front();
          check("tt", tt, e.tt);
          check("ones", 128'(ones), 128'(e.ones));
        end
      end
    end
  end

  // Monitor for the SETTLE_CYCLES = 3 DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid3 && ready3) begin
        if (q3.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected result3: got tt %0h ones %0d, none expected", tt3, ones3);
        end else begin
          e = q3.pop_front();
          check("tt3", tt3, e.tt);
          check("ones3", 128'(ones3), 128'(e.ones));
        end
      end
    end
  end

  // One full sweep on the default DUT with latency and handshake checks.
  task automatic sweep(input int m, input tt_t etv, input logic [7:0] eo,
                       input bit early_ready, input bit mid_start);
    int lat;
    bit to;
    mode = m;
    q1.push_back('{tt: etv, ones: eo});
    ready = early_ready;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy after accept", 128'(busy), 128'(1));
    lat = 1;
    to  = 1'b0;
    while (!valid && !to) begin
      if (mid_start && lat == 100) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (lat > 2000) to = 1'b1;
    end
    check("latency", 128'(lat), 128'(257));
    check("busy at valid", 128'(busy), 128'(0));
    check("x holds 127", 128'(x), 128'(127));
    if (early_ready) begin
      // Start in the acceptance cycle must not launch a new sweep.
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("valid drop", 128'(valid), 128'(0));
      check("no restart", 128'(busy), 128'(0));
      @(posedge clk);
      #1;
      check("still idle", 128'(busy), 128'(0));
      check("tt kept in idle", tt, etv);
      ready = 1'b0;
    end else begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        check("valid hold", 128'(valid), 128'(1));
      end
      check("tt stable", tt, etv);
      ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
      check("valid drop", 128'(valid), 128'(0));
    end
  endtask

  initial begin
    int lat;
    bit found;
    start  = 1'b0;
    ready  = 1'b0;
    start3 = 1'b0;
    ready3 = 1'b0;

    #12;
    check("reset x", 128'(x), 128'(0));
    check("reset tt", tt, 128'(0));
    check("reset ones", 128'(ones), 128'(0));
    check("reset busy", 128'(busy), 128'(0));
    check("reset valid", 128'(valid), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    sweep(0, 128'h0, 8'd0, 1'b0, 1'b0);
    sweep(1, {128{1'b1}}, 8'd128, 1'b1, 1'b0);
    sweep(2, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 8'd64, 1'b0, 1'b1);
    sweep(3, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, 8'd64, 1'b1, 1'b0);
    sweep(4, maj_tt, popcount(maj_tt), 1'b0, 1'b0);

    // Reset in the middle of a sweep discards the partial table.
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (x == 7'd60) found = 1'b1;
    end
    check("reach minterm 60", 128'(x), 128'(60));
    check("partial tt nonzero", 128'(tt != '0), 128'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset x", 128'(x), 128'(0));
    check("mid reset tt", tt, 128'(0));
    check("mid reset ones", 128'(ones), 128'(0));
    check("mid reset busy", 128'(busy), 128'(0));
    check("mid reset valid", 128'(valid), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    sweep(4, maj_tt, popcount(maj_tt), 1'b0, 1'b0);

    // Longer settle delay.
    q3.push_back('{tt: 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, ones: 8'd64});
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    lat = 1;
    while (!valid3 && lat <= 4000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency3", 128'(lat), 128'(513));
    ready3 = 1'b1;
    @(posedge clk);
    #1;
    ready3 = 1'b0;
    check("valid3 drop", 128'(valid3), 128'(0));

    repeat (3) @(posedge clk);
    check("q1 drained", 128'(q1.size()), 128'(0));
    check("q3 drained", 128'(q3.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
